uart_cmd_parse: RTL and testbench

Downstream consumer of the UART receiver, in the clk_rx domain of the Programmable Wave Generator. Takes the receiver's byte strobe and assembles ASCII commands. Decoded commands become single-cycle register write/read/go strobes with address and data. Each command produces one status response for the response generator, through a valid/ready handshake.

---
 rtl/uart_cmd_parse.sv | 209 ++++++++++++++++++++
 tb/tb_uart_cmd_parse.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parse.sv
// ASCII command parser for the UART receive path: turns "*W", "*R" and "*G" lines into
// one-cycle register strobes plus one status response per command over valid/ready.
module uart_cmd_parse #(
    parameter int unsigned ADDR_DIGITS = 2,
    parameter int unsigned DATA_DIGITS = 4,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic                     clk_rx,
    input  logic                     rst_clk_rx,
    input  logic [7:0]               rx_data,
    input  logic                     rx_data_rdy,
    output logic                     cmd_wr_en,
    output logic                     cmd_rd_en,
    output logic                     cmd_go,
    output logic [4*ADDR_DIGITS-1:0] cmd_addr,
    output logic [4*DATA_DIGITS-1:0] cmd_data,
    output logic                     resp_valid,
    output logic [1:0]               resp_code,
    input  logic                     resp_ready
);

    localparam int unsigned AW     = 4 * ADDR_DIGITS;
    localparam int unsigned DW     = 4 * DATA_DIGITS;
    localparam int unsigned MaxDig = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int unsigned CntW   = $clog2(MaxDig + 1);
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_DIGITS - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_DIGITS - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] RespOk      = 2'd0;
    localparam logic [1:0] RespSyntax  = 2'd1;
    localparam logic [1:0] RespTimeout = 2'd2;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StSep, StData, StEol, StResp} state_e;
    typedef enum logic [1:0] {OpWrite, OpRead, OpGo} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [AW-1:0]   addr_sh_q, addr_sh_d, cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]   data_sh_q, data_sh_d, cmd_data_q, cmd_data_d;
    logic            wr_en_q, wr_en_d, rd_en_q, rd_en_d, go_q, go_d;
    logic            resp_valid_q, resp_valid_d;
    logic [1:0]      resp_code_q, resp_code_d;

    logic       is_hex;
    logic [3:0] hex_val;
    logic [7:0] lc;
    logic       active;
    logic       err;

    // Forcing bit 5 folds upper-case letters onto lower case without disturbing digits.
    always_comb begin
        lc      = rx_data | 8'h20;
        is_hex  = 1'b1;
        hex_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_val = rx_data[3:0];
        end else if (lc >= 8'h61 && lc <= 8'h66) begin
            hex_val = rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    assign active = (state_q != StIdle) && (state_q != StResp);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        addr_sh_d    = addr_sh_q;
        data_sh_d    = data_sh_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        go_d         = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_code_d  = resp_code_q;
        err          = 1'b0;
        tmo_d        = (rx_data_rdy || !active) ? '0 : tmo_q + 1'b1;

        if (state_q == StIdle) begin
            if (rx_data_rdy && rx_data == 8'h2A) state_d = StCmd;
        end else if (state_q == StResp) begin
            // Characters are dropped here, including on the accept cycle.
            if (resp_ready) begin
                state_d      = StIdle;
                resp_valid_d = 1'b0;
                resp_code_d  = RespOk;
            end
        end else if (rx_data_rdy) begin
            if (rx_data == 8'h2A) begin
                state_d = StCmd;
                cnt_d   = '0;
            end else begin
                err = 1'b1;
                case (state_q)
                    StCmd: begin
                        err   = 1'b0;
                        cnt_d = '0;
                        if (lc == 8'h77) begin
                            op_d    = OpWrite;
                            state_d = StAddr;
                        end else if (lc == 8'h72) begin
                            op_d    = OpRead;
                            state_d = StAddr;
                        end else if (lc == 8'h67) begin
                            op_d    = OpGo;
                            state_d = StEol;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    StAddr: if (is_hex) begin
                        err       = 1'b0;
                        addr_sh_d = (addr_sh_q << 4) | AW'(hex_val);
                        if (cnt_q == AddrLast) begin
                            cnt_d   = '0;
                            state_d = (op_q == OpWrite) ? StSep : StEol;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    StSep: if (rx_data == 8'h20) begin
                        err     = 1'b0;
                        state_d = StData;
                    end
                    StData: if (is_hex) begin
                        err       = 1'b0;
                        data_sh_d = (data_sh_q << 4) | DW'(hex_val);
                        if (cnt_q == DataLast) begin
                            cnt_d   = '0;
                            state_d = StEol;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    StEol: if (rx_data == 8'h0D) begin
                        err          = 1'b0;
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_code_d  = RespOk;
                        wr_en_d      = (op_q == OpWrite);
                        rd_en_d      = (op_q == OpRead);
                        go_d         = (op_q == OpGo);
                        if (op_q != OpGo) cmd_addr_d = addr_sh_q;
                        if (op_q == OpWrite) cmd_data_d = data_sh_q;
                    end
                    default: ;
                endcase
                if (err) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_code_d  = RespSyntax;
                end
            end
        end else if (tmo_q == TmoLast) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_code_d  = RespTimeout;
        end
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) begin
            state_q      <= StIdle;
            op_q         <= OpWrite;
            cnt_q        <= '0;
            tmo_q        <= '0;
            addr_sh_q    <= '0;
            data_sh_q    <= '0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            go_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RespOk;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            addr_sh_q    <= addr_sh_d;
            data_sh_q    <= data_sh_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            go_q         <= go_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign cmd_wr_en  = wr_en_q;
    assign cmd_rd_en  = rd_en_q;
    assign cmd_go     = go_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_data   = cmd_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;

endmodule

// File: tb/tb_uart_cmd_parse.sv
// Directed bench for uart_cmd_parse: writes, reads, syntax errors, timeout, backpressure,
// '*' restart and asynchronous reset, with hand-computed expectations.
module tb_uart_cmd_parse;

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx;
    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        cmd_wr_en, cmd_rd_en, cmd_go;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic        resp_ready;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, rd_cnt = 0, go_cnt = 0;

    uart_cmd_parse #(
        .ADDR_DIGITS(2),
        .DATA_DIGITS(4),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .rx_data    (rx_data),
        .rx_data_rdy(rx_data_rdy),
        .cmd_wr_en  (cmd_wr_en),
        .cmd_rd_en  (cmd_rd_en),
        .cmd_go     (cmd_go),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .resp_ready (resp_ready)
    );

    always #5 clk_rx = ~clk_rx;

    always @(negedge clk_rx) begin
        if (cmd_wr_en) wr_cnt++;
        if (cmd_rd_en) rd_cnt++;
        if (cmd_go) go_cnt++;
    end

    task automatic clear_counts();
        @(posedge clk_rx);
        #1;
        wr_cnt = 0;
        rd_cnt = 0;
        go_cnt = 0;
    endtask

    // Drives one strobe; returns on the falling edge right after the sampling edge.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk_rx);
        rx_data     = c;
        rx_data_rdy = 1'b1;
        @(negedge clk_rx);
        rx_data_rdy = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        rst_clk_rx = 1'b0;
        rx_data = 8'h00;
        rx_data_rdy = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk_rx);
        total++;
        if ({cmd_wr_en, cmd_rd_en, cmd_go, cmd_addr, cmd_data, resp_valid, resp_code} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wr=%b rd=%b go=%b addr=%h data=%h v=%b code=%0d want all 0",
                     cmd_wr_en, cmd_rd_en, cmd_go, cmd_addr, cmd_data, resp_valid, resp_code);
        end
        rst_clk_rx = 1'b1;
        repeat (2) @(negedge clk_rx);
    endtask

    task automatic test_write();
        clear_counts();
        send_str("*W1A BEEF");
        send_char(8'h0D);
        total++;
        if ({cmd_wr_en, cmd_rd_en, cmd_go} !== 3'b100 || cmd_addr !== 8'h1A || cmd_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_exec: got wr/rd/go=%b%b%b addr=%h data=%h want 100 1a beef",
                     cmd_wr_en, cmd_rd_en, cmd_go, cmd_addr, cmd_data);
        end
        total++;
        if (resp_valid !== 1'b1 || resp_code !== 2'd0) begin
            bad++;
            $display("FAIL write_resp: got v=%b code=%0d want v=1 code=0", resp_valid, resp_code);
        end
        @(negedge clk_rx);
        total++;
        if (cmd_wr_en !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_clear: got wr=%b v=%b want 0 0", cmd_wr_en, resp_valid);
        end
        @(negedge clk_rx);
        total++;
        if (wr_cnt != 1) begin
            bad++;
            $display("FAIL write_pulse_count: got %0d want 1", wr_cnt);
        end
    endtask

    task automatic test_read();
        clear_counts();
        send_str("*r3c");
        send_char(8'h0D);
        total++;
        if ({cmd_wr_en, cmd_rd_en, cmd_go} !== 3'b010 || cmd_addr !== 8'h3C || cmd_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL read_exec: got wr/rd/go=%b%b%b addr=%h data=%h want 010 3c beef",
                     cmd_wr_en, cmd_rd_en, cmd_go, cmd_addr, cmd_data);
        end
        total++;
        if (resp_valid !== 1'b1 || resp_code !== 2'd0) begin
            bad++;
            $display("FAIL read_resp: got v=%b code=%0d want v=1 code=0", resp_valid, resp_code);
        end
        repeat (2) @(negedge clk_rx);
        total++;
        if (wr_cnt != 0 || rd_cnt != 1 || go_cnt != 0) begin
            bad++;
            $display("FAIL read_counts: got wr=%0d rd=%0d go=%0d want 0 1 0", wr_cnt, rd_cnt, go_cnt);
        end
    endtask

    task automatic test_syntax();
        clear_counts();
        send_str("*W1G");
        total++;
        if (resp_valid !== 1'b1 || resp_code !== 2'd1 || cmd_addr !== 8'h3C) begin
            bad++;
            $display("FAIL syntax_resp: got v=%b code=%0d addr=%h want 1 1 3c",
                     resp_valid, resp_code, cmd_addr);
        end
        repeat (2) @(negedge clk_rx);
        total++;
        if (wr_cnt + rd_cnt + go_cnt != 0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL syntax_nostrobe: got strobes=%0d v=%b want 0 0",
                     wr_cnt + rd_cnt + go_cnt, resp_valid);
        end
        send_str("*G");
        send_char(8'h0D);
        total++;
        if ({cmd_wr_en, cmd_rd_en, cmd_go} !== 3'b001 || resp_valid !== 1'b1 || resp_code !== 2'd0
            || cmd_addr !== 8'h3C || cmd_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL go_exec: got wr/rd/go=%b%b%b v=%b code=%0d addr=%h data=%h want 001 1 0 3c beef",
                     cmd_wr_en, cmd_rd_en, cmd_go, resp_valid, resp_code, cmd_addr, cmd_data);
        end
        repeat (2) @(negedge clk_rx);
    endtask

    task automatic test_timeout();
        clear_counts();
        send_str("*W1");
        repeat (99) @(negedge clk_rx);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got v=%b 99 cycles after last char want 0", resp_valid);
        end
        @(negedge clk_rx);
        total++;
        if (resp_valid !== 1'b1 || resp_code !== 2'd2) begin
            bad++;
            $display("FAIL timeout_fire: got v=%b code=%0d want v=1 code=2", resp_valid, resp_code);
        end
        repeat (2) @(negedge clk_rx);
        total++;
        if (resp_valid !== 1'b0 || wr_cnt != 0) begin
            bad++;
            $display("FAIL timeout_after: got v=%b wr=%0d want 0 0", resp_valid, wr_cnt);
        end
        // Next character lands exactly on the expiry cycle and must win.
        send_str("*W1");
        repeat (98) @(negedge clk_rx);
        send_char("A");
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_prevented: got v=%b code=%0d want v=0", resp_valid, resp_code);
        end
        send_str(" 0001");
        send_char(8'h0D);
        total++;
        if (cmd_wr_en !== 1'b1 || cmd_addr !== 8'h1A || cmd_data !== 16'h0001 || resp_code !== 2'd0) begin
            bad++;
            $display("FAIL timeout_resume: got wr=%b addr=%h data=%h code=%0d want 1 1a 0001 0",
                     cmd_wr_en, cmd_addr, cmd_data, resp_code);
        end
        repeat (2) @(negedge clk_rx);
    endtask

    task automatic test_backpressure();
        clear_counts();
        resp_ready = 1'b0;
        send_str("*G");
        send_char(8'h0D);
        send_str("*G");
        send_char(8'h0D);
        repeat (3) @(negedge clk_rx);
        total++;
        if (resp_valid !== 1'b1 || resp_code !== 2'd0 || go_cnt != 1) begin
            bad++;
            $display("FAIL bp_hold: got v=%b code=%0d go=%0d want 1 0 1", resp_valid, resp_code, go_cnt);
        end
        resp_ready = 1'b1;
        @(negedge clk_rx);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: got v=%b want 0", resp_valid);
        end
        repeat (3) @(negedge clk_rx);
        total++;
        if (go_cnt != 1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_dropped: got go=%0d v=%b want 1 0", go_cnt, resp_valid);
        end
    endtask

    task automatic test_restart();
        clear_counts();
        send_str("*W12*R05");
        send_char(8'h0D);
        total++;
        if (cmd_rd_en !== 1'b1 || cmd_addr !== 8'h05 || cmd_data !== 16'h0001 || resp_code !== 2'd0) begin
            bad++;
            $display("FAIL restart_read: got rd=%b addr=%h data=%h code=%0d want 1 05 0001 0",
                     cmd_rd_en, cmd_addr, cmd_data, resp_code);
        end
        repeat (2) @(negedge clk_rx);
        total++;
        if (wr_cnt != 0 || rd_cnt != 1) begin
            bad++;
            $display("FAIL restart_counts: got wr=%0d rd=%0d want 0 1", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_async_reset();
        send_str("*W1A BE");
        @(negedge clk_rx);
        #2;
        rst_clk_rx = 1'b0;
        #1;
        total++;
        if ({cmd_wr_en, cmd_rd_en, cmd_go, cmd_addr, cmd_data, resp_valid, resp_code} !== '0) begin
            bad++;
            $display("FAIL async_reset: got addr=%h data=%h v=%b code=%0d want all 0",
                     cmd_addr, cmd_data, resp_valid, resp_code);
        end
        @(negedge clk_rx);
        rst_clk_rx = 1'b1;
        clear_counts();
        send_str("*G");
        send_char(8'h0D);
        total++;
        if (cmd_go !== 1'b1 || resp_valid !== 1'b1 || resp_code !== 2'd0 || cmd_addr !== 8'h00) begin
            bad++;
            $display("FAIL post_reset_go: got go=%b v=%b code=%0d addr=%h want 1 1 0 00",
                     cmd_go, resp_valid, resp_code, cmd_addr);
        end
        repeat (2) @(negedge clk_rx);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_syntax();
        test_timeout();
        test_backpressure();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
